// File: rtl/hdu_pkg.sv
// Shared encodings and the tracked-stage record for the hazard detection unit.
package hdu_pkg;

  // Register indices are zero-extended into this width; REG_ADDR_W must not exceed it.
  localparam int unsigned HDU_RD_W = 8;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ALU  = 2'b01;
  localparam logic [1:0] OP_LD   = 2'b10;
  localparam logic [1:0] OP_ST   = 2'b11;

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_EX_ALU  = 2'b01;
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;
  localparam logic [1:0] FWD_MEM_LD  = 2'b11;

  typedef struct packed {
    logic [1:0]          optype;
    logic [HDU_RD_W-1:0] rd;
    logic                we;
  } stage_t;

  // A stage only produces a hazard when it writes a non-zero register.
  function automatic logic src_hit(input logic use_i, input logic [HDU_RD_W-1:0] rs,
                                   input stage_t st);
    return use_i && st.we && (st.rd != '0) && (st.rd == rs);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic use_i, input logic [HDU_RD_W-1:0] rs,
                                         input stage_t ex, input stage_t mem);
    logic [1:0] sel;
    sel = FWD_RF;
    if (src_hit(use_i, rs, ex) && (ex.optype == OP_ALU))
      sel = FWD_EX_ALU;
    else if (src_hit(use_i, rs, mem) && (mem.optype == OP_ALU))
      sel = FWD_MEM_ALU;
    else if (src_hit(use_i, rs, mem) && (mem.optype == OP_LD))
      sel = FWD_MEM_LD;
    return sel;
  endfunction

endpackage

// File: rtl/hdu_stage_reg.sv
// One tracked pipeline stage record; a bubble loads an empty record.
module hdu_stage_reg
  import hdu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   bubble,
  input  stage_t d,
  output stage_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         q <= '0;
    else if (bubble) q <= '0;
    else             q <= d;
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// Pipeline hazard detection: stall/flush control and operand forwarding selects.
// Define HDU_FORWARD_EN for forwarding; otherwise any EX/MEM dependency stalls.
module hazard_detection_unit
  import hdu_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rs1use_ID,
  input  logic                  rs2_use_ID,
  input  logic [REG_ADDR_W-1:0] rs1_ID,
  input  logic [REG_ADDR_W-1:0] rs2_ID,
  input  logic [REG_ADDR_W-1:0] rd_ID,
  input  logic [1:0]            hazard_optype_ID,
  input  logic                  RegWrite_ID,
  input  logic                  Branch_ID,
  output logic                  PC_EN_IF,
  output logic                  reg_FD_EN,
  output logic                  reg_FD_flush,
  output logic                  reg_DE_flush,
  output logic [1:0]            forward_ctrl_A,
  output logic [1:0]            forward_ctrl_B,
  output logic                  forward_ctrl_ls
);

  logic [HDU_RD_W-1:0] rs1_x, rs2_x;
  stage_t              id_rec, ex_rec, mem_rec;
  logic                stall_raw, stall;
  logic [1:0]          fa_raw, fb_raw;

  assign rs1_x  = HDU_RD_W'(rs1_ID);
  assign rs2_x  = HDU_RD_W'(rs2_ID);
  assign id_rec = '{optype: hazard_optype_ID, rd: HDU_RD_W'(rd_ID), we: RegWrite_ID};

  hdu_stage_reg u_ex (
    .clk    (clk),
    .rst    (rst),
    .bubble (stall),
    .d      (id_rec),
    .q      (ex_rec)
  );

  hdu_stage_reg u_mem (
    .clk    (clk),
    .rst    (rst),
    .bubble (1'b0),
    .d      (ex_rec),
    .q      (mem_rec)
  );

`ifdef HDU_FORWARD_EN
  logic hit1_ex, hit2_ex, ex_is_ld, ls_c, ls_q;

  assign hit1_ex  = src_hit(rs1use_ID, rs1_x, ex_rec);
  assign hit2_ex  = src_hit(rs2_use_ID, rs2_x, ex_rec);
  assign ex_is_ld = (ex_rec.optype == OP_LD);
  // Store data from a just-loaded register is patched in from WB, so no stall.
  assign ls_c      = ex_is_ld && (hazard_optype_ID == OP_ST) && hit2_ex && !hit1_ex;
  assign stall_raw = ex_is_ld && (hit1_ex || hit2_ex) && !ls_c;
  assign fa_raw    = fwd_sel(rs1use_ID, rs1_x, ex_rec, mem_rec);
  assign fb_raw    = fwd_sel(rs2_use_ID, rs2_x, ex_rec, mem_rec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ls_q <= 1'b0;
    else     ls_q <= ls_c;
  end

  assign forward_ctrl_ls = ls_q;
`else
  logic unused_optype;

  // Without forwarding, wait until the producer has left MEM.
  assign stall_raw = src_hit(rs1use_ID, rs1_x, ex_rec)  || src_hit(rs2_use_ID, rs2_x, ex_rec) ||
                     src_hit(rs1use_ID, rs1_x, mem_rec) || src_hit(rs2_use_ID, rs2_x, mem_rec);
  assign fa_raw          = FWD_RF;
  assign fb_raw          = FWD_RF;
  assign forward_ctrl_ls = 1'b0;
  assign unused_optype   = ^{ex_rec.optype, mem_rec.optype};
`endif

  // Reset overrides every decision in the same cycle.
  assign stall          = !rst && stall_raw;
  assign PC_EN_IF       = !stall;
  assign reg_FD_EN      = !stall;
  assign reg_DE_flush   = stall;
  assign reg_FD_flush   = !rst && Branch_ID && !stall;
  assign forward_ctrl_A = rst ? FWD_RF : fa_raw;
  assign forward_ctrl_B = rst ? FWD_RF : fb_raw;

endmodule
